uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte sources. It accepts one byte at a time from a requester, issues it to the transmitter through that block's `i_Tx_DV`/`i_Tx_Byte` inputs, and tracks the transmitter's `o_Tx_Active`/`o_Tx_Done` outputs. It returns a per-requester completion pulse, so that no two bytes overlap on the serial line. It sits between the system-side byte producers and the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `IDX_W`, default 2: width of the requester index, equal to clog2(`NUM_REQ`).
- `i_Clock`  in  1: system clock; all logic triggers on the rising edge.
- `i_Rst_n`  in  1: asynchronous, active-low reset.
- `i_Req`  in  NUM_REQ: per-requester request. Level signal, held until the matching `o_Gnt` bit pulses.
- `i_Req_Byte`  in  8*NUM_REQ: byte for requester k on bits [8k+7:8k]. Held stable while `i_Req[k]` is high.
- `o_Gnt`  out  NUM_REQ: one-hot, one-cycle acceptance pulse.
- `o_Done`  out  NUM_REQ: one-hot, one-cycle pulse when the stop bit of the owner's byte has completed.
- `o_Busy`  out  1: high whenever the state is not IDLE.
- `o_Owner`  out  IDX_W: index of the current or last granted requester.
- `o_Tx_DV`  out  1: connects to the transmitter's `i_Tx_DV`.
- `o_Tx_Byte`  out  8: connects to the transmitter's `i_Tx_Byte`.
- `i_Tx_Active`  in  1: from the transmitter's `o_Tx_Active`.
- `i_Tx_Done`  in  1: from the transmitter's `o_Tx_Done`. This signal is high for 2 consecutive cycles per byte.

## Operation
- States: IDLE, ISSUE, WAIT_ACT, WAIT_DONE, SETTLE.
- **IDLE**
  - When `i_Req` is nonzero, pick the first set bit searching upward from `o_Owner`+1, wrapping modulo `NUM_REQ`.
  - Register the winner into `o_Owner`, latch its byte into `o_Tx_Byte`, pulse its `o_Gnt` bit, drive `o_Tx_DV`=1, and go to ISSUE.
- **ISSUE**
  - Drive `o_Tx_DV`=0 and go to WAIT_ACT.
  - `o_Tx_DV` is therefore high for exactly one cycle.
- **WAIT_ACT**
  - Wait for `i_Tx_Active`=1, then go to WAIT_DONE.
- **WAIT_DONE**
  - On the first cycle with `i_Tx_Done`=1, pulse `o_Done[o_Owner]` and go to SETTLE.
- **SETTLE**
  - Wait until `i_Tx_Done`=0 and `i_Tx_Active`=0, then go to IDLE.
  - This state absorbs the second cycle of `i_Tx_Done`, so each byte produces exactly one `o_Done` pulse.
- Round-robin: the requester granted most recently has the lowest priority at the next arbitration. A requester that holds `i_Req` continuously gets at most one grant per `NUM_REQ` grants while others are requesting.
- `o_Tx_Byte` holds its value between grants; it changes only when a grant occurs in IDLE.
- Requests that arrive or drop outside IDLE are ignored until the next IDLE cycle.
- A requester may drop `i_Req` before its grant without side effects.

## Timing
- Reset values: `o_Gnt`=0, `o_Done`=0, `o_Busy`=0, `o_Owner`=`NUM_REQ`-1 (so requester 0 wins first), `o_Tx_DV`=0, `o_Tx_Byte`=0, state IDLE.
- Reset asserted mid-byte: all outputs return to reset values immediately. No `o_Done` is issued for the byte in flight. The transmitter is not reset by this block.
- Request to `o_Gnt`/`o_Tx_DV`: 1 cycle. The request is seen at edge N; the outputs are registered at edge N+1.
- `o_Done` rises 1 cycle after the first high cycle of `i_Tx_Done`.
- Minimum spacing between grants, with the transmitter at `CLKS_PER_BIT`=2: 24 cycles (10 bits × 2 cycles + handshake overhead). The bench measures and checks this exact value.
- `o_Gnt` and `o_Done` are never high in the same cycle.

## Configuration
- Macro: `UART_TX_ARB_FRAME_LOCK_EN`.
- Defined:
  - Adds input `i_Req_Last`, `NUM_REQ` bits wide, sampled together with `i_Req`.
  - After a grant with `i_Req_Last[owner]`=0, the next arbitration in IDLE considers only `o_Owner`.
  - The lock holds until a byte with its `i_Req_Last` bit set is granted, or until the owner drops `i_Req` while in IDLE.
  - This keeps multi-byte frames contiguous on the line.
- Undefined:
  - The port is absent.
  - Pure per-byte round-robin applies.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants `ARB_IDLE`..`ARB_SETTLE` (3 bits);
  - the data width constant (8);
  - the frame-bit count constant (10).
- Sub-module `rr_picker`: purely combinational rotate-priority encoder. Inputs are `i_Req` and the last owner; outputs are a one-hot winner and its index. It is reusable by a future receiver-side dispatcher.

## Test plan
- Single request: `i_Req`=0001 with byte 0xA5.
  - `o_Gnt`=0001 and `o_Tx_DV`=1 for exactly one cycle, with `o_Tx_Byte`=0xA5.
  - The transmitter's line output matches 0,1,0,1,0,0,1,0,1,1.
  - Exactly one `o_Done`=0001 pulse.
- All four requesting, bytes 0x11/0x22/0x33/0x44.
  - Grant order 0,1,2,3.
  - Then 0 again if `i_Req[0]` is still held.
  - No overlap between `o_Tx_Active` windows.
- Two-cycle `i_Tx_Done`: exactly one `o_Done` per byte across 8 back-to-back bytes.
- Reset mid-byte: deassert `i_Rst_n` during WAIT_DONE.
  - Outputs go to reset values asynchronously.
  - After release, requester 0 wins first.
- Request withdrawn: raise `i_Req[2]` during WAIT_DONE for requester 1, then drop it before IDLE → requester 2 receives no grant.
- With `UART_TX_ARB_FRAME_LOCK_EN` defined: requester 1 sends 3 bytes with `i_Req_Last`=0,0,1 while requester 0 also requests → grant order 1,1,1,0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the arbiter state encoding
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_ISSUE     = 3'd1,
    ARB_WAIT_ACT  = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_SETTLE    = 3'd4
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte handshake between the arbiter (master) and a UART transmitter (slave)
interface uart_tx_arbiter_if;
  import uart_pkg::*;
  logic              Tx_DV;
  logic [DATA_W-1:0] Tx_Byte;
  logic              Tx_Active;
  logic              Tx_Done;
  modport master (output Tx_DV, Tx_Byte, input Tx_Active, Tx_Done);
  modport slave (input Tx_DV, Tx_Byte, output Tx_Active, Tx_Done);
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder, search starts just above the last owner
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [IDX_W-1:0]   i_Last,
  output logic [NUM_REQ-1:0] o_Win,
  output logic [IDX_W-1:0]   o_Win_Idx
);
  logic [IDX_W-1:0] k;
  // walk from farthest to nearest candidate so the nearest set bit above i_Last wins
  always_comb begin
    k = '0;
    o_Win_Idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IDX_W'((int'(i_Last) + i) % NUM_REQ);
      if (i_Req[k]) o_Win_Idx = k;
    end
    o_Win = (|i_Req) ? NUM_REQ'(1) << o_Win_Idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; `UART_TX_ARB_FRAME_LOCK_EN adds frame locking
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_n,
  input  logic [NUM_REQ-1:0]        i_Req,
  input  logic [DATA_W*NUM_REQ-1:0] i_Req_Byte,
`ifdef UART_TX_ARB_FRAME_LOCK_EN
  input  logic [NUM_REQ-1:0]        i_Req_Last,
`endif
  output logic [NUM_REQ-1:0]        o_Gnt,
  output logic [NUM_REQ-1:0]        o_Done,
  output logic                      o_Busy,
  output logic [IDX_W-1:0]          o_Owner,
  uart_tx_arbiter_if.master         tx
);
  arb_state_t state, state_nx;
  logic [NUM_REQ-1:0] req_eff, win, own_oh;
  logic [IDX_W-1:0] win_idx;
  logic [DATA_W-1:0] byte_sel;
  logic grant, fin;
  assign own_oh = NUM_REQ'(1) << o_Owner;
  assign o_Busy = state != ARB_IDLE;
  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_Req(req_eff),
    .i_Last(o_Owner),
    .o_Win(win),
    .o_Win_Idx(win_idx)
  );
`ifdef UART_TX_ARB_FRAME_LOCK_EN
  logic lock;
  assign req_eff = (lock && i_Req[o_Owner]) ? own_oh : i_Req;
  // lock follows the last flag of each granted byte; an owner leaving in IDLE releases it
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) lock <= 1'b0;
    else if (grant) lock <= !i_Req_Last[win_idx];
    else if (state == ARB_IDLE && !i_Req[o_Owner]) lock <= 1'b0;
`else
  assign req_eff = i_Req;
`endif
  // byte of the winning requester
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) byte_sel = i_Req_Byte[i*DATA_W +: DATA_W];
  end
  // next state: arbitrate in IDLE, then follow the transmitter through one byte
  always_comb begin
    state_nx = state;
    grant = 1'b0;
    fin = 1'b0;
    case (state)
      ARB_IDLE: begin
        grant = |req_eff;
        state_nx = grant ? ARB_ISSUE : ARB_IDLE;
      end
      ARB_ISSUE: state_nx = ARB_WAIT_ACT;
      ARB_WAIT_ACT: state_nx = tx.Tx_Active ? ARB_WAIT_DONE : ARB_WAIT_ACT;
      ARB_WAIT_DONE: begin
        fin = tx.Tx_Done;
        state_nx = fin ? ARB_SETTLE : ARB_WAIT_DONE;
      end
      ARB_SETTLE: state_nx = (tx.Tx_Done || tx.Tx_Active) ? ARB_SETTLE : ARB_IDLE;
      default: state_nx = ARB_IDLE;
    endcase
  end
  // state and registered outputs; owner and byte only move on a grant
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state <= ARB_IDLE;
      o_Gnt <= '0;
      o_Done <= '0;
      o_Owner <= IDX_W'(NUM_REQ - 1);
      tx.Tx_DV <= 1'b0;
      tx.Tx_Byte <= '0;
    end else begin
      state <= state_nx;
      o_Gnt <= grant ? win : '0;
      o_Done <= fin ? own_oh : '0;
      tx.Tx_DV <= grant;
      if (grant) begin
        o_Owner <= win_idx;
        tx.Tx_Byte <= byte_sel;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vectors, directed corner cases and a randomized round-robin model with a CLKS_PER_BIT=2 transmitter
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  logic i_Clock = 1'b0;
  logic i_Rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_byte = '0;
  logic [3:0] gnt, done;
  logic busy;
  logic [1:0] owner;
  logic line;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, gnt_cnt = 0, done_cnt = 0;
  logic [3:0] last_done = '0;
  logic td1 = 1'b0, td2 = 1'b0;
  bit line_q[$];
  int tx_cnt = 0;
  logic [9:0] tx_frame = '1;
`ifdef UART_TX_ARB_FRAME_LOCK_EN
  logic [3:0] req_last = '1;
`endif
  uart_tx_arbiter_if tx_if();
  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .i_Req(req),
    .i_Req_Byte(req_byte),
`ifdef UART_TX_ARB_FRAME_LOCK_EN
    .i_Req_Last(req_last),
`endif
    .o_Gnt(gnt),
    .o_Done(done),
    .o_Busy(busy),
    .o_Owner(owner),
    .tx(tx_if)
  );
  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;
  // transmitter model: 10 bits of 2 cycles, done high on the last stop-bit cycle and the one after
  always @(posedge i_Clock)
    if (tx_cnt == 0) begin
      if (tx_if.Tx_DV) begin
        tx_frame <= {1'b1, tx_if.Tx_Byte, 1'b0};
        tx_cnt <= 1;
      end
    end else tx_cnt <= (tx_cnt == 2*FRAME_BITS + 1) ? 0 : tx_cnt + 1;
  assign tx_if.Tx_Active = tx_cnt >= 1 && tx_cnt <= 2*FRAME_BITS;
  assign tx_if.Tx_Done = tx_cnt >= 2*FRAME_BITS && tx_cnt <= 2*FRAME_BITS + 1;
  assign line = tx_if.Tx_Active ? tx_frame[4'((tx_cnt - 1) / 2)] : 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // per-cycle monitor
  always @(posedge i_Clock) begin
    #1;
    if (i_Rst_n) begin
      if (tx_if.Tx_Active) line_q.push_back(line);
      if (gnt != 0 || done != 0) begin
        chk("gnt_done_excl", 32'((gnt != 0) && (done != 0)), 0);
        chk("onehot", {30'b0, $onehot0(gnt), $onehot0(done)}, 3);
        chk("dv_with_gnt", 32'(tx_if.Tx_DV), 32'(gnt != 0));
      end
      if (gnt != 0) gnt_cnt++;
      if (done != 0) begin
        done_cnt++;
        last_done = done;
        chk("done_timing", {30'b0, td2, td1}, 1);
      end
    end
    td2 = td1;
    td1 = tx_if.Tx_Done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int rr(input logic [3:0] m, input int last);
    for (int i = 1; i <= 4; i++) if (m[(last + i) % 4]) return (last + i) % 4;
    return 7;
  endfunction

  task automatic wait_gnt(input string nm, input int lim);
    int n = 0;
    @(negedge i_Clock);
    while (gnt == 0 && n < lim) begin
      @(negedge i_Clock);
      n++;
    end
    chk(nm, 32'(gnt != 0), 1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    @(negedge i_Clock);
    while ((busy || tx_if.Tx_Active || tx_if.Tx_Done) && n < lim) begin
      @(negedge i_Clock);
      n++;
    end
    chk(nm, 32'(busy || tx_if.Tx_Active || tx_if.Tx_Done), 0);
  endtask

  task automatic pulse_rst();
    @(negedge i_Clock);
    i_Rst_n = 1'b0;
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] bytes;
    logic [3:0]  gnt;
    logic [7:0]  byt;
  } vec_t;
  vec_t vec[9];

  initial begin
    int d0, g0, pc, mlast, k, ng, dprev;
    logic [9:0] bits;
    vec[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
    vec[1] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
    vec[2] = '{4'b0011, 32'h44332211, 4'b0001, 8'h11};
    vec[3] = '{4'b1000, 32'h44332211, 4'b1000, 8'h44};
    vec[4] = '{4'b1001, 32'h44332211, 4'b0001, 8'h11};
    vec[5] = '{4'b0001, 32'h44332211, 4'b0001, 8'h11};
    vec[6] = '{4'b0110, 32'h44332211, 4'b0010, 8'h22};
    vec[7] = '{4'b0110, 32'h44332211, 4'b0100, 8'h33};
    vec[8] = '{4'b0101, 32'h44332211, 4'b0001, 8'h11};
    repeat (3) @(negedge i_Clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 3);
    chk("rst_dv", tx_if.Tx_DV, 0);
    chk("rst_byte", tx_if.Tx_Byte, 0);
    i_Rst_n = 1'b1;
    for (int v = 0; v < 9; v++) begin
      req = vec[v].req;
      req_byte = vec[v].bytes;
      line_q.delete();
      d0 = done_cnt;
      wait_gnt($sformatf("vec%0d_gnt_timeout", v), 40);
      chk($sformatf("vec%0d_gnt", v), gnt, vec[v].gnt);
      chk($sformatf("vec%0d_dv", v), tx_if.Tx_DV, 1);
      chk($sformatf("vec%0d_byte", v), tx_if.Tx_Byte, vec[v].byt);
      req = '0;
      @(negedge i_Clock);
      chk($sformatf("vec%0d_pulse", v), {gnt, tx_if.Tx_DV}, 0);
      wait_idle($sformatf("vec%0d_idle", v), 80);
      chk($sformatf("vec%0d_done_cnt", v), done_cnt - d0, 1);
      chk($sformatf("vec%0d_done_idx", v), last_done, vec[v].gnt);
      chk($sformatf("vec%0d_byte_hold", v), tx_if.Tx_Byte, vec[v].byt);
      if (v == 0) begin
        chk("line_len", line_q.size(), 2*FRAME_BITS);
        bits = '0;
        for (int b = 0; b < 2*FRAME_BITS; b += 2) bits = {bits[8:0], line_q[b]};
        chk("line_bits", bits, 10'b0101001011);
      end
    end
    // back-to-back bytes from four held requests
    pulse_rst();
    req = 4'b1111;
    req_byte = 32'h44332211;
    pc = 0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      wait_gnt($sformatf("b2b%0d_timeout", i), 60);
      chk($sformatf("b2b%0d_gnt", i), gnt, 4'b0001 << (i % 4));
      chk($sformatf("b2b%0d_byte", i), tx_if.Tx_Byte, 8'(8'h11 * (i % 4 + 1)));
      chk($sformatf("b2b%0d_no_overlap", i), tx_if.Tx_Active, 0);
      if (i > 0) begin
        chk($sformatf("b2b%0d_spacing", i), cyc - pc, 2*FRAME_BITS + 4);
        chk($sformatf("b2b%0d_done_cnt", i), done_cnt - d0, 1);
        chk($sformatf("b2b%0d_done_idx", i), last_done, 4'b0001 << ((i - 1) % 4));
      end
      pc = cyc;
      d0 = done_cnt;
    end
    // reset in the middle of requester 3's byte
    req = '0;
    repeat (10) @(negedge i_Clock);
    chk("mid_busy", busy, 1);
    #2 i_Rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 3);
    chk("mid_rst_dv", tx_if.Tx_DV, 0);
    chk("mid_rst_byte", tx_if.Tx_Byte, 0);
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    req = 4'b0101;
    wait_gnt("mid_after_timeout", 10);
    chk("mid_after_gnt", gnt, 4'b0001);
    req = '0;
    wait_idle("mid_idle", 100);
    // withdrawn request during another requester's byte
    req = 4'b0010;
    wait_gnt("wd_timeout", 10);
    chk("wd_gnt", gnt, 4'b0010);
    req = '0;
    g0 = gnt_cnt;
    repeat (8) @(negedge i_Clock);
    req = 4'b0100;
    repeat (4) @(negedge i_Clock);
    req = '0;
    wait_idle("wd_idle", 80);
    repeat (3) @(negedge i_Clock);
    chk("wd_no_gnt", gnt_cnt - g0, 0);
    req = 4'b1000;
    wait_gnt("wd_next_timeout", 10);
    chk("wd_next_gnt", gnt, 4'b1000);
    req = '0;
    wait_idle("wd_next_idle", 80);
`ifdef UART_TX_ARB_FRAME_LOCK_EN
    // three-byte frame from requester 1 stays contiguous
    req_last = 4'b0001;
    req = 4'b0001;
    wait_gnt("fl_pre_timeout", 10);
    req = '0;
    wait_idle("fl_pre_idle", 80);
    req = 4'b0011;
    for (int j = 0; j < 4; j++) begin
      wait_gnt($sformatf("fl%0d_timeout", j), 60);
      chk($sformatf("fl%0d_gnt", j), gnt, (j < 3) ? 4'b0010 : 4'b0001);
      if (j == 1) req_last = 4'b0011;
      if (j == 2) req = 4'b0001;
      if (j == 3) req = '0;
    end
    wait_idle("fl_idle", 80);
    req_last = '1;
`endif
    // randomized traffic against a round-robin model
    pulse_rst();
    mlast = 3;
    ng = 0;
    dprev = done_cnt;
    for (int c = 0; c < 4000 && ng < 40; c++) begin
      @(negedge i_Clock);
      if (gnt != 0) begin
        k = rr(req, mlast);
        chk("rnd_gnt", gnt, 4'b0001 << k);
        chk("rnd_byte", tx_if.Tx_Byte, req_byte[(k % 4)*8 +: 8]);
        if (ng > 0) begin
          chk("rnd_done_cnt", done_cnt - dprev, 1);
          chk("rnd_done_idx", last_done, 4'b0001 << mlast);
        end
        dprev = done_cnt;
        mlast = k;
        ng++;
        req[k % 4] = 1'b0;
      end
      for (int j = 0; j < 4; j++)
        if (!req[j] && $urandom_range(7) == 0) begin
          req[j] = 1'b1;
          req_byte[j*8 +: 8] = 8'($urandom);
        end else if (req[j] && $urandom_range(63) == 0) req[j] = 1'b0;
    end
    chk("rnd_grants", ng, 40);
    req = '0;
    wait_idle("rnd_idle", 100);
    chk("rnd_last_done_cnt", done_cnt - dprev, 1);
    chk("rnd_last_done_idx", last_done, 4'b0001 << mlast);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
